// File: rtl/rom_loader_if.sv
// ============================================================================
//  Module      : rom_loader_if
//  Description : ROM read port and memory write port seen by the boot loader.
//                The master side is the loader; the slave side is the ROM
//                and memory write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rom_loader_if;
  // ROM read port: combinational byte and last-address flag
  logic [31:0] rom_address;
  logic [7:0]  rom_byte;
  logic        rom_done;

  // Memory write port: request held until acknowledged
  logic [31:0] mem_address;
  logic [7:0]  mem_data;
  logic        mem_write_request;
  logic        mem_write_ack;

  modport master (
    output rom_address,
    input  rom_byte,
    input  rom_done,
    output mem_address,
    output mem_data,
    output mem_write_request,
    input  mem_write_ack
  );

  modport slave (
    input  rom_address,
    output rom_byte,
    output rom_done,
    input  mem_address,
    input  mem_data,
    input  mem_write_request,
    output mem_write_ack
  );
endinterface

`default_nettype wire

// File: rtl/rom_loader.sv
// ============================================================================
//  Module      : rom_loader
//  Description : Boot-time sequencer. Copies the program ROM byte by byte
//                into main memory through a request/acknowledge write port,
//                holding the CPU in reset until the copy has finished.
//                Stops on the ROM done flag or on the MAX_BYTES length guard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [31:0] MAX_BYTES = 32'd65536
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        start,
  rom_loader_if.master     bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             load_complete,
  output logic             overrun,
  output logic [31:0]      bytes_written
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ROM address that is forced to be the final byte of the image
  localparam logic [31:0] LAST_ADDR = MAX_BYTES - 32'd1;
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  state_t      state_q,         state_d;
  logic [31:0] rom_address_q,   rom_address_d;
  logic [31:0] mem_address_q,   mem_address_d;
  logic [7:0]  mem_data_q,      mem_data_d;
  logic        mem_request_q,   mem_request_d;
  logic        cpu_hold_q,      cpu_hold_d;
  logic        overrun_q,       overrun_d;
  logic [31:0] bytes_written_q, bytes_written_d;
  logic        last_q,          last_d;
  logic        guard_q,         guard_d;

  logic        at_guard_addr;

  assign at_guard_addr = (rom_address_q == LAST_ADDR);

  // Next-state and datapath: one FETCH cycle to capture the ROM byte, then
  // WRITE until the arbiter accepts it.
  always_comb begin
    state_d         = state_q;
    rom_address_d   = rom_address_q;
    mem_address_d   = mem_address_q;
    mem_data_d      = mem_data_q;
    cpu_hold_d      = cpu_hold_q;
    overrun_d       = overrun_q;
    bytes_written_d = bytes_written_q;
    last_d          = last_q;
    guard_d         = guard_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d         = S_FETCH;
          rom_address_d   = 32'd0;
          mem_address_d   = BASE_ADDR;
          bytes_written_d = 32'd0;
          overrun_d       = 1'b0;
          cpu_hold_d      = 1'b1;
        end
      end

      S_FETCH: begin
        // rom_done is only trusted here, while rom_address is stable
        mem_data_d = bus.rom_byte;
        last_d     = bus.rom_done | at_guard_addr;
        guard_d    = ~bus.rom_done & at_guard_addr;
        state_d    = S_WRITE;
      end

      S_WRITE: begin
        if (bus.mem_write_ack) begin
          if (bytes_written_q != COUNT_MAX) begin
            bytes_written_d = bytes_written_q + 32'd1;
          end
          if (last_q) begin
            state_d    = S_DONE;
            overrun_d  = guard_q;
            cpu_hold_d = 1'b0;
          end else begin
            // Memory address tracks BASE_ADDR + rom_address and may wrap
            rom_address_d = rom_address_q + 32'd1;
            mem_address_d = mem_address_q + 32'd1;
            state_d       = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request is registered so it is high exactly while in WRITE
    mem_request_d = (state_d == S_WRITE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rom_address_q   <= 32'd0;
      mem_address_q   <= BASE_ADDR;
      mem_data_q      <= 8'd0;
      mem_request_q   <= 1'b0;
      cpu_hold_q      <= 1'b1;
      overrun_q       <= 1'b0;
      bytes_written_q <= 32'd0;
      last_q          <= 1'b0;
      guard_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      rom_address_q   <= rom_address_d;
      mem_address_q   <= mem_address_d;
      mem_data_q      <= mem_data_d;
      mem_request_q   <= mem_request_d;
      cpu_hold_q      <= cpu_hold_d;
      overrun_q       <= overrun_d;
      bytes_written_q <= bytes_written_d;
      last_q          <= last_d;
      guard_q         <= guard_d;
    end
  end

  assign bus.rom_address       = rom_address_q;
  assign bus.mem_address       = mem_address_q;
  assign bus.mem_data          = mem_data_q;
  assign bus.mem_write_request = mem_request_q;
  assign cpu_hold              = cpu_hold_q;
  assign busy                  = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign load_complete         = (state_q == S_DONE);
  assign overrun               = overrun_q;
  assign bytes_written         = bytes_written_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Scoreboard bench for rom_loader. Three loaders differ only
//                in parameters: 0 = plain image, 1 = length guard of 16
//                bytes, 2 = base address near the top of the address space.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];

  int ack_max    = 0;
  int k1_done_at = -1;

  logic        start_s [3];
  logic        stray   [3];
  logic [31:0] rom_a   [3];
  logic [31:0] mem_a   [3];
  logic [7:0]  mem_d   [3];
  logic        req     [3];
  logic        ack     [3];
  logic        hold    [3];
  logic        busy_o  [3];
  logic        lc      [3];
  logic        ovr     [3];
  logic [31:0] bw      [3];

  // ROM image content: byte = 118*a + 134 (mod 256); 12 -> 14, 275 -> 72
  function automatic logic [7:0] rom_f(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'd118 + 32'd134;
    return t[7:0];
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'hFFFF_FFF0 : 32'd0;
  endfunction

  rom_loader_if bus [3] ();

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam logic [31:0] P_BASE = (k == 2) ? 32'hFFFF_FFF0 : 32'd0;
      localparam logic [31:0] P_MAX  = (k == 1) ? 32'd16 : 32'd65536;

      logic [2:0] wcnt;
      logic [2:0] wtgt;

      assign bus[k].rom_byte = rom_f(bus[k].rom_address);
      assign bus[k].rom_done = (k == 1)
          ? ((k1_done_at >= 0) && (bus[k].rom_address == 32'(k1_done_at)))
          : (bus[k].rom_address == 32'd291);
      assign bus[k].mem_write_ack =
          (bus[k].mem_write_request && (wcnt == wtgt)) || stray[k];

      assign rom_a[k] = bus[k].rom_address;
      assign mem_a[k] = bus[k].mem_address;
      assign mem_d[k] = bus[k].mem_data;
      assign req[k]   = bus[k].mem_write_request;
      assign ack[k]   = bus[k].mem_write_ack;

      rom_loader #(.BASE_ADDR(P_BASE), .MAX_BYTES(P_MAX)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start_s[k]),
        .bus           (bus[k]),
        .cpu_hold      (hold[k]),
        .busy          (busy_o[k]),
        .load_complete (lc[k]),
        .overrun       (ovr[k]),
        .bytes_written (bw[k])
      );

      // Memory responder: acknowledges each request after 0..ack_max cycles
      always @(posedge clock or posedge reset) begin
        if (reset) begin
          wcnt <= 3'd0;
          wtgt <= 3'd0;
        end else if (req[k] && ack[k]) begin
          wcnt <= 3'd0;
          wtgt <= 3'($urandom_range(ack_max, 0));
        end else if (req[k]) begin
          wcnt <= wcnt + 3'd1;
        end
      end
    end
  endgenerate

  // Monitor: pops the scoreboard on every accepted write and checks the
  // request protocol (held stable, dropped the cycle after its ack).
  logic        p_req  [3];
  logic        p_ack  [3];
  logic [31:0] p_addr [3];
  logic [7:0]  p_data [3];

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        p_req[k] <= 1'b0;
        p_ack[k] <= 1'b0;
      end else begin
        if (p_req[k] && p_ack[k]) begin
          checks++;
          if (req[k]) begin
            errors++;
            $display("FAIL req_drop inst%0d: request=%b required 0", k, req[k]);
          end
        end
        if (p_req[k] && !p_ack[k] && req[k]) begin
          checks++;
          if (mem_a[k] != p_addr[k] || mem_d[k] != p_data[k]) begin
            errors++;
            $display("FAIL hold_stable inst%0d: addr=%h data=%h required addr=%h data=%h",
                     k, mem_a[k], mem_d[k], p_addr[k], p_data[k]);
          end
        end
        if (req[k] && ack[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write inst%0d: unexpected write addr=%h data=%h required none",
                     k, mem_a[k], mem_d[k]);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (e.addr != mem_a[k] || e.data != mem_d[k]) begin
              errors++;
              $display("FAIL write inst%0d: addr=%h data=%h required addr=%h data=%h",
                       k, mem_a[k], mem_d[k], e.addr, e.data);
            end
          end
          if (k == 0 && mem_a[k] == 32'd12) begin
            checks++;
            if (mem_d[k] != 8'd14) begin
              errors++;
              $display("FAIL byte12: data=%0d required 14", mem_d[k]);
            end
          end
          if (k == 0 && mem_a[k] == 32'd275) begin
            checks++;
            if (mem_d[k] != 8'd72) begin
              errors++;
              $display("FAIL byte275: data=%0d required 72", mem_d[k]);
            end
          end
        end
        p_req[k]  <= req[k];
        p_ack[k]  <= ack[k];
        p_addr[k] <= mem_a[k];
        p_data[k] <= mem_d[k];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp_v);
    end
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_req%0d", k),   32'(req[k]),    32'd0);
    chk($sformatf("rst_hold%0d", k),  32'(hold[k]),   32'd1);
    chk($sformatf("rst_busy%0d", k),  32'(busy_o[k]), 32'd0);
    chk($sformatf("rst_lc%0d", k),    32'(lc[k]),     32'd0);
    chk($sformatf("rst_ovr%0d", k),   32'(ovr[k]),    32'd0);
    chk($sformatf("rst_bw%0d", k),    bw[k],          32'd0);
    chk($sformatf("rst_rom%0d", k),   rom_a[k],       32'd0);
    chk($sformatf("rst_mem%0d", k),   mem_a[k],       base_of(k));
    chk($sformatf("rst_data%0d", k),  32'(mem_d[k]),  32'd0);
  endtask

  task automatic push_image(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = base_of(k) + 32'(i);
      e.data = rom_f(32'(i));
      exp_q.push_back(e);
    end
  endtask

  // Runs a complete load on loader k and checks the end state
  task automatic do_load(input int k, input int n, input bit exp_ovr,
                         input bit chk_time, input bit extra);
    int cyc;
    bit done;
    push_image(k, n);
    @(negedge clock);
    start_s[k] = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      start_s[k] = extra && (cyc == 40 || cyc == 101);
      if (cyc == 1) begin
        chk($sformatf("entry_ovr%0d", k),  32'(ovr[k]),    32'd0);
        chk($sformatf("entry_bw%0d", k),   bw[k],          32'd0);
        chk($sformatf("entry_hold%0d", k), 32'(hold[k]),   32'd1);
        chk($sformatf("entry_busy%0d", k), 32'(busy_o[k]), 32'd1);
      end
      if (lc[k]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL load_timeout inst%0d: no load_complete after %0d cycles", k, cyc);
    end else begin
      if (chk_time) chk($sformatf("complete_cycle%0d", k), 32'(cyc), 32'(2 * n + 1));
      chk($sformatf("end_bw%0d", k),   bw[k],          32'(n));
      chk($sformatf("end_ovr%0d", k),  32'(ovr[k]),    32'(exp_ovr));
      chk($sformatf("end_hold%0d", k), 32'(hold[k]),   32'd0);
      chk($sformatf("end_req%0d", k),  32'(req[k]),    32'd0);
      chk($sformatf("end_busy%0d", k), 32'(busy_o[k]), 32'd0);
    end
    chk($sformatf("queue_empty%0d", k), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      stray[k]   = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 3; k++) chk_reset(k);

    // Stray acknowledge while idle must not start anything
    stray[0] = 1'b1;
    repeat (2) @(negedge clock);
    stray[0] = 1'b0;
    @(negedge clock);
    chk("stray_busy", 32'(busy_o[0]), 32'd0);
    chk("stray_bw",   bw[0],          32'd0);
    chk("stray_rom",  rom_a[0],       32'd0);

    // Zero-wait acknowledge: 292 bytes in 2N+1 cycles
    ack_max = 0;
    do_load(0, 292, 1'b0, 1'b1, 1'b0);

    // Random 0-5 cycle ack, extra start pulses mid-load, reload from DONE
    ack_max = 5;
    do_load(0, 292, 1'b0, 1'b0, 1'b1);

    // Length guard: done never asserts, 16 bytes then overrun
    ack_max    = 2;
    k1_done_at = -1;
    do_load(1, 16, 1'b1, 1'b0, 1'b0);
    // Reload from DONE clears overrun; image now ends at address 5
    k1_done_at = 5;
    do_load(1, 6, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the WRITE for byte 100
    ack_max = 3;
    push_image(0, 292);
    @(negedge clock);
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    cyc = 0;
    while (!(bw[0] == 32'd100 && req[0]) && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    chk("reach_byte100", 32'(req[0] && bw[0] == 32'd100), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset(0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_busy", 32'(busy_o[0]), 32'd0);
    ack_max = 0;
    do_load(0, 292, 1'b0, 1'b1, 1'b0);

    // Base address wraps to 0 after 16 writes
    ack_max = 0;
    do_load(2, 292, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
